// File: rtl/pipe_reg_n.sv
// pipe_reg_n: N-stage pipeline register for DSP operand/result paths.
// Each stage carries a data word and a valid tag. The block also keeps an
// occupancy count of the valid stages. DEPTH=0 gives a purely
// combinational bypass.
module pipe_reg_n #(
  parameter int               WIDTH        = 18,
  parameter int               DEPTH        = 1,
  parameter logic [WIDTH-1:0] RST_VAL      = '0,
  parameter bit               HOLD_INVALID = 1'b0,
  parameter int               CNT_W        = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ce,
  input  logic             i_sclr,
  input  logic             i_in_vld,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_out,
  output logic             o_out_vld,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  // Catch illegal parameter sets at elaboration.
  // The count must be able to hold DEPTH.
  if ((WIDTH < 1) || (DEPTH < 0) || (DEPTH > 16) || (CNT_W < 1) ||
      ((CNT_W < 31) && ((1 << CNT_W) <= DEPTH))) begin : g_param_err
    $error("pipe_reg_n: illegal parameters WIDTH=%0d DEPTH=%0d CNT_W=%0d",
           WIDTH, DEPTH, CNT_W);
  end

  if (DEPTH == 0) begin : g_bypass
    // No storage. Clock, reset and control inputs are intentionally ignored.
    logic w_unused_ctrl;
    assign w_unused_ctrl = ^{i_clk, i_rst_n, i_ce, i_sclr};

    assign o_out     = i_in;
    assign o_out_vld = i_in_vld;
    assign o_count   = '0;
    assign o_full    = 1'b1;
    assign o_empty   = 1'b1;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] w_data_in [DEPTH];
    logic [DEPTH-1:0] w_vld_in;

    // Word and tag presented to each stage: the input port for stage 0,
    // otherwise the previous stage.
    always_comb begin
      w_vld_in     = '0;
      w_vld_in[0]  = i_in_vld;
      w_data_in[0] = i_in;
      for (int k = 1; k < DEPTH; k++) begin
        w_data_in[k] = r_data[k-1];
        w_vld_in[k]  = r_vld[k-1];
      end
    end

    // Stage registers.
    // The valid tags always advance when enabled. With HOLD_INVALID set,
    // a data stage keeps its last valid word when an invalid slot passes
    // through it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_vld <= '0;
        for (int k = 0; k < DEPTH; k++) r_data[k] <= RST_VAL;
      end else if (i_sclr) begin
        r_vld <= '0;
        for (int k = 0; k < DEPTH; k++) r_data[k] <= RST_VAL;
      end else if (i_ce) begin
        r_vld <= w_vld_in;
        for (int k = 0; k < DEPTH; k++) begin
          if (!HOLD_INVALID || w_vld_in[k]) r_data[k] <= w_data_in[k];
        end
      end
    end

    // Occupancy counter.
    // A word entering adds one and a word leaving the last stage subtracts
    // one, so the count equals the number of set valid tags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_count <= '0;
      end else if (i_sclr) begin
        r_count <= '0;
      end else if (i_ce) begin
        r_count <= r_count + CNT_W'(i_in_vld) - CNT_W'(r_vld[DEPTH-1]);
      end
    end

    assign o_out     = r_data[DEPTH-1];
    assign o_out_vld = r_vld[DEPTH-1];
    assign o_count   = r_count;
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
  end

endmodule

// File: tb/tb_pipe_reg_n.sv
// tb_pipe_reg_n: directed checks of pipe_reg_n.
// Several parameter sets share one stimulus bus.
module tb_pipe_reg_n;

  localparam int W  = 18;
  localparam int CW = 5;

  logic          clk;
  logic          rst_n;
  logic          ce;
  logic          sclr;
  logic          in_vld;
  logic [W-1:0]  din;

  logic [W-1:0]  out_d3, out_d4, out_h1, out_h0, out_d0;
  logic          vld_d3, vld_d4, vld_h1, vld_h0, vld_d0;
  logic [CW-1:0] cnt_d3, cnt_d4, cnt_h1, cnt_h0, cnt_d0;
  logic          full_d3, full_d4, full_h1, full_h0, full_d0;
  logic          emp_d3, emp_d4, emp_h1, emp_h0, emp_d0;

  int n_checks = 0;
  int n_errors = 0;

  pipe_reg_n #(.WIDTH(W), .DEPTH(3), .RST_VAL(18'h0A5), .HOLD_INVALID(1'b0), .CNT_W(CW)) u_d3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_sclr(sclr), .i_in_vld(in_vld), .i_in(din),
    .o_out(out_d3), .o_out_vld(vld_d3), .o_count(cnt_d3), .o_full(full_d3), .o_empty(emp_d3));

  pipe_reg_n #(.WIDTH(W), .DEPTH(4), .RST_VAL(18'h03C), .HOLD_INVALID(1'b0), .CNT_W(CW)) u_d4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_sclr(sclr), .i_in_vld(in_vld), .i_in(din),
    .o_out(out_d4), .o_out_vld(vld_d4), .o_count(cnt_d4), .o_full(full_d4), .o_empty(emp_d4));

  pipe_reg_n #(.WIDTH(W), .DEPTH(2), .RST_VAL(18'h000), .HOLD_INVALID(1'b1), .CNT_W(CW)) u_h1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_sclr(sclr), .i_in_vld(in_vld), .i_in(din),
    .o_out(out_h1), .o_out_vld(vld_h1), .o_count(cnt_h1), .o_full(full_h1), .o_empty(emp_h1));

  pipe_reg_n #(.WIDTH(W), .DEPTH(2), .RST_VAL(18'h077), .HOLD_INVALID(1'b0), .CNT_W(CW)) u_h0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_sclr(sclr), .i_in_vld(in_vld), .i_in(din),
    .o_out(out_h0), .o_out_vld(vld_h0), .o_count(cnt_h0), .o_full(full_h0), .o_empty(emp_h0));

  pipe_reg_n #(.WIDTH(W), .DEPTH(0), .RST_VAL(18'h000), .HOLD_INVALID(1'b0), .CNT_W(CW)) u_d0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_sclr(sclr), .i_in_vld(in_vld), .i_in(din),
    .o_out(out_d0), .o_out_vld(vld_d0), .o_count(cnt_d0), .o_full(full_d0), .o_empty(emp_d0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         ce;
    logic         sclr;
    logic         vld;
    logic [W-1:0] din;
    logic [W-1:0] exp_out;
    logic         exp_vld;
    logic [CW-1:0] exp_cnt;
    logic         exp_full;
    logic         exp_empty;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(logic c, logic s, logic v, logic [W-1:0] d,
                              logic [W-1:0] eo, logic ev, logic [CW-1:0] ec,
                              logic ef, logic ee);
    vec_t r;
    r.ce = c; r.sclr = s; r.vld = v; r.din = d;
    r.exp_out = eo; r.exp_vld = ev; r.exp_cnt = ec; r.exp_full = ef; r.exp_empty = ee;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic s, input logic v, input logic [W-1:0] d);
    ce = c; sclr = s; in_vld = v; din = d;
  endtask

  // Expected values for the hold-invalid sequence, one entry per edge.
  logic [W-1:0] exp_h1_out [5];
  logic         exp_h1_vld [5];
  logic [W-1:0] exp_h0_out [5];
  logic         exp_h0_vld [5];

  initial begin
    // DEPTH=3: load 1,2,3, stall 5 cycles, push 4, then drain with
    // invalid words 0x11/0x22/0x33.
    vecs[0]  = mk(1, 0, 1, 18'h1,  18'h0A5, 0, 5'd1, 0, 0);
    vecs[1]  = mk(1, 0, 1, 18'h2,  18'h0A5, 0, 5'd2, 0, 0);
    vecs[2]  = mk(1, 0, 1, 18'h3,  18'h001, 1, 5'd3, 1, 0);
    vecs[3]  = mk(0, 0, 1, 18'h9,  18'h001, 1, 5'd3, 1, 0);
    vecs[4]  = mk(0, 0, 1, 18'h9,  18'h001, 1, 5'd3, 1, 0);
    vecs[5]  = mk(0, 0, 1, 18'h9,  18'h001, 1, 5'd3, 1, 0);
    vecs[6]  = mk(0, 0, 1, 18'h9,  18'h001, 1, 5'd3, 1, 0);
    vecs[7]  = mk(0, 0, 1, 18'h9,  18'h001, 1, 5'd3, 1, 0);
    vecs[8]  = mk(1, 0, 1, 18'h4,  18'h002, 1, 5'd3, 1, 0);
    vecs[9]  = mk(1, 0, 0, 18'h11, 18'h003, 1, 5'd2, 0, 0);
    vecs[10] = mk(1, 0, 0, 18'h22, 18'h004, 1, 5'd1, 0, 0);
    vecs[11] = mk(1, 0, 0, 18'h33, 18'h011, 0, 5'd0, 0, 1);

    exp_h1_out = '{18'h000, 18'h155, 18'h155, 18'h155, 18'h155};
    exp_h1_vld = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_h0_out = '{18'h077, 18'h155, 18'h3FF, 18'h3FF, 18'h3FF};
    exp_h0_vld = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset values.
    rst_n = 1'b0;
    drive(1, 0, 1, 18'h3AA);
    #12;
    chk("rst_out",   32'(out_d3),  32'h0A5);
    chk("rst_vld",   32'(vld_d3),  32'h0);
    chk("rst_cnt",   32'(cnt_d3),  32'h0);
    chk("rst_empty", 32'(emp_d3),  32'h1);
    chk("rst_full",  32'(full_d3), 32'h0);
    rst_n = 1'b1;

    // Latency and stall table.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].ce, vecs[i].sclr, vecs[i].vld, vecs[i].din);
      tick();
      chk($sformatf("vec%0d_out", i),   32'(out_d3),  32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_vld", i),   32'(vld_d3),  32'(vecs[i].exp_vld));
      chk($sformatf("vec%0d_cnt", i),   32'(cnt_d3),  32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_full", i),  32'(full_d3), 32'(vecs[i].exp_full));
      chk($sformatf("vec%0d_empty", i), 32'(emp_d3),  32'(vecs[i].exp_empty));
    end

    // sclr with ce=0 on a full DEPTH=4 pipe.
    drive(1, 1, 0, 18'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 18'h100 + 18'(i));
      tick();
    end
    chk("d4_fill_cnt",  32'(cnt_d4),  32'd4);
    chk("d4_fill_full", 32'(full_d4), 32'h1);
    chk("d4_fill_out",  32'(out_d4),  32'h100);
    chk("d4_fill_vld",  32'(vld_d4),  32'h1);
    drive(0, 1, 1, 18'h1FF);
    tick();
    chk("sclr_out",   32'(out_d4),  32'h03C);
    chk("sclr_vld",   32'(vld_d4),  32'h0);
    chk("sclr_cnt",   32'(cnt_d4),  32'h0);
    chk("sclr_empty", 32'(emp_d4),  32'h1);
    chk("sclr_full",  32'(full_d4), 32'h0);
    drive(1, 0, 0, 18'h0);
    tick();
    chk("sclr_after_vld", 32'(vld_d4), 32'h0);
    chk("sclr_after_out", 32'(out_d4), 32'h03C);

    // Hold-invalid versus free-running data on DEPTH=2.
    drive(1, 1, 0, 18'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(1, 0, 1, 18'h155);
      else        drive(1, 0, 0, 18'h3FF);
      tick();
      chk($sformatf("h1_out%0d", i), 32'(out_h1), 32'(exp_h1_out[i]));
      chk($sformatf("h1_vld%0d", i), 32'(vld_h1), 32'(exp_h1_vld[i]));
      chk($sformatf("h0_out%0d", i), 32'(out_h0), 32'(exp_h0_out[i]));
      chk($sformatf("h0_vld%0d", i), 32'(vld_h0), 32'(exp_h0_vld[i]));
    end
    chk("h1_cnt_end", 32'(cnt_h1), 32'h0);

    // Bypass: combinational and unaffected by ce/sclr.
    drive(0, 1, 1, 18'h2AB);
    #1;
    chk("byp_out",   32'(out_d0),  32'h2AB);
    chk("byp_vld",   32'(vld_d0),  32'h1);
    chk("byp_cnt",   32'(cnt_d0),  32'h0);
    chk("byp_full",  32'(full_d0), 32'h1);
    chk("byp_empty", 32'(emp_d0),  32'h1);
    drive(1, 0, 0, 18'h0F0);
    #1;
    chk("byp_out2", 32'(out_d0), 32'h0F0);
    chk("byp_vld2", 32'(vld_d0), 32'h0);

    // Async reset between edges, mid-stream on DEPTH=2.
    drive(1, 1, 0, 18'h0);
    tick();
    drive(1, 0, 1, 18'h010);
    tick();
    drive(1, 0, 1, 18'h020);
    tick();
    chk("ar_pre_out", 32'(out_h0), 32'h010);
    chk("ar_pre_cnt", 32'(cnt_h0), 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_out",   32'(out_h0), 32'h077);
    chk("ar_vld",   32'(vld_h0), 32'h0);
    chk("ar_cnt",   32'(cnt_h0), 32'h0);
    chk("ar_empty", 32'(emp_h0), 32'h1);
    rst_n = 1'b1;
    drive(1, 0, 1, 18'h055);
    tick();
    chk("ar_e1_vld", 32'(vld_h0), 32'h0);
    chk("ar_e1_out", 32'(out_h0), 32'h077);
    drive(1, 0, 0, 18'h0);
    tick();
    chk("ar_e2_out", 32'(out_h0), 32'h055);
    chk("ar_e2_vld", 32'(vld_h0), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_reg_n.md
Name: pipe_reg_n

Overview:
Parametrised N-stage pipeline register. It generalises the single-stage DSP operand/result register to a configurable depth, including a zero-stage bypass. It adds valid tagging, synchronous clear, optional hold-on-invalid data gating, and an occupancy counter. It sits on DSP slice operand and result paths wherever programmable pipeline latency is required, such as A/B/C/D/M/P stage chains.

Parameters:
WIDTH, 18, data width in bits (>=1)
DEPTH, 1, number of register stages (0..16); 0 = combinational bypass
RST_VAL, 0, data value loaded on reset or sclr (WIDTH bits)
HOLD_INVALID, 0, 1 = a data stage loads only when its incoming valid bit is 1
CNT_W, 5, width of count output; must satisfy 2^CNT_W > DEPTH

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous reset, active-low
ce  input  1  clock enable for the whole chain; 0 = stall (all stages hold)
sclr  input  1  synchronous clear, active-high
in_vld  input  1  valid tag for in
in  input  WIDTH  data input
out  output  WIDTH  data from the last stage
out_vld  output  1  valid tag of the last stage
count  output  CNT_W  number of stages currently holding valid data (0..DEPTH)
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Reset (rst=0, asynchronous, immediate): every data stage = RST_VAL, every valid bit = 0, count = 0. Outputs: out=RST_VAL, out_vld=0, count=0, full=0 (DEPTH>=1), empty=1.
- Priority on each rising edge: rst > sclr > ce.
- sclr=1: the same clear as reset, applied synchronously. It takes effect even when ce=0.
- ce=1, sclr=0:
  - stage0 <= in; stage k <= stage k-1 (k=1..DEPTH-1).
  - Valid bits shift identically.
  - out/out_vld come from stage DEPTH-1.
- ce=0, sclr=0: all stages, valid bits and count hold.
- Latency: in reaches out exactly DEPTH enabled (ce=1) edges later. Stalled cycles add no shift.
- HOLD_INVALID=1:
  - Data stage k loads only when ce=1 and the valid bit entering it is 1; otherwise its data holds.
  - Valid bits always shift on ce=1.
  - Result: out keeps the last valid word while out_vld=0.
- HOLD_INVALID=0: data shifts unconditionally on ce=1.
- count update on ce=1, sclr=0: count_next = count + in_vld - out_vld (out_vld = the bit leaving the last stage).
  - Simultaneous enter and leave leaves count unchanged.
  - count never exceeds DEPTH and never goes below 0 (guaranteed by construction).
- full and empty are combinational decodes of registered count.
- DEPTH=0:
  - out = in, out_vld = in_vld (combinational).
  - count = 0, empty = 1, full = 1.
  - ce, sclr and HOLD_INVALID have no effect.
  - No registers are inferred.
- Reset asserted mid-stream discards all in-flight words. The first word after rst deasserts appears DEPTH enabled edges later.
- Parameter check: DEPTH > 16 or 2^CNT_W <= DEPTH must be a simulation-time error.

Test Plan:
- Reset values: DEPTH=3, WIDTH=18, RST_VAL=18'h0_0A5. Hold rst=0 -> out=0x0A5, out_vld=0, count=0, empty=1, full=0.
- Latency: DEPTH=3, ce=1. Drive in=1,2,3,4 with in_vld=1 on consecutive edges -> out=1 with out_vld=1 after the 3rd edge; count=3 and full=1 from the 3rd edge; out=4 after the 6th edge.
- Stall: DEPTH=3. After loading 1,2,3, drop ce for 5 cycles -> out, out_vld and count frozen. Restore ce -> shifting resumes with no lost or duplicated words.
- sclr priority: DEPTH=4, pipeline full. Assert sclr with ce=0 for one edge -> all valid bits 0, out=RST_VAL, count=0, empty=1.
- Hold-invalid: HOLD_INVALID=1, DEPTH=2. Drive in=0x155 valid, then in=0x3FF with in_vld=0 for 4 edges -> out stays 0x155 with out_vld going 1 then 0. Repeat with HOLD_INVALID=0 -> out becomes 0x3FF.
- Bypass and async reset: with DEPTH=0, in=0x2AB, in_vld=1 -> out=0x2AB, out_vld=1 in the same cycle. With DEPTH=2, pulse rst low between clock edges mid-stream -> outputs clear immediately, before the next edge.
